// File: rtl/zacore_mem_arbiter.sv
// Memory-port arbiter for Zacore: fetch and LSU share one memory port, one
// transaction in flight, LSU priority with a starvation guard for fetch.
module zacore_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,

  input  logic        i_fetch_req,
  input  logic [31:0] i_fetch_addr,
  output logic        o_fetch_gnt,
  output logic        o_fetch_rvalid,
  output logic [31:0] o_fetch_rdata,

  input  logic        i_lsu_req,
  input  logic        i_lsu_we,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  input  logic [3:0]  i_lsu_be,
  output logic        o_lsu_gnt,
  output logic        o_lsu_rvalid,
  output logic [31:0] o_lsu_rdata,

  input  logic        i_invalidate,

  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    REQ_F,
    REQ_L,
    WAIT_F,
    WAIT_L
  } state_e;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             drop_q, drop_d;

  logic lsu_wins;
  logic fetch_wins;
  logic own_f;
  logic own_l;
  logic fetch_gnt;
  logic lsu_gnt;
  logic fetch_rvalid;
  logic lsu_rvalid;

  // Arbitration and ownership; in IDLE the owner is the combinational winner,
  // in REQ_x it is locked by the state itself.
  always_comb begin
    lsu_wins     = i_lsu_req && (!i_fetch_req || (starve_cnt_q < LIMIT));
    fetch_wins   = i_fetch_req && !lsu_wins;
    own_f        = ((state_q == IDLE) && fetch_wins) || (state_q == REQ_F);
    own_l        = ((state_q == IDLE) && lsu_wins)   || (state_q == REQ_L);
    fetch_gnt    = own_f && i_mem_gnt;
    lsu_gnt      = own_l && i_mem_gnt;
    fetch_rvalid = (state_q == WAIT_F) && i_mem_rvalid && !drop_q && !i_invalidate;
    lsu_rvalid   = (state_q == WAIT_L) && i_mem_rvalid;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (lsu_wins)        state_d = i_mem_gnt ? WAIT_L : REQ_L;
        else if (fetch_wins) state_d = i_mem_gnt ? WAIT_F : REQ_F;
      end
      REQ_F:   if (i_mem_gnt)    state_d = WAIT_F;
      REQ_L:   if (i_mem_gnt)    state_d = WAIT_L;
      WAIT_F:  if (i_mem_rvalid) state_d = IDLE;
      WAIT_L:  if (i_mem_rvalid) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Counter only advances while below the limit, so it saturates there.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fetch_gnt) begin
      starve_cnt_d = '0;
    end else if ((state_q == IDLE) && i_fetch_req && lsu_wins &&
                 (starve_cnt_q < LIMIT)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    drop_d = drop_q;
    case (state_q)
      IDLE:   if (fetch_gnt && i_invalidate) drop_d = 1'b1;
      REQ_F:  if (i_invalidate)              drop_d = 1'b1;
      WAIT_F: begin
        if (i_mem_rvalid)      drop_d = 1'b0;
        else if (i_invalidate) drop_d = 1'b1;
      end
      WAIT_L: if (i_mem_rvalid)              drop_d = 1'b0;
      default:                               drop_d = drop_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      drop_q       <= drop_d;
    end
  end

  // Outputs are combinational off state and inputs, so they are explicitly
  // forced low while reset is asserted.
  always_comb begin
    o_mem_req      = 1'b0;
    o_mem_we       = 1'b0;
    o_mem_addr     = '0;
    o_mem_wdata    = '0;
    o_mem_be       = '0;
    o_fetch_gnt    = 1'b0;
    o_lsu_gnt      = 1'b0;
    o_fetch_rvalid = 1'b0;
    o_lsu_rvalid   = 1'b0;
    o_fetch_rdata  = '0;
    o_lsu_rdata    = '0;
    if (i_rst) begin
      if (own_l) begin
        o_mem_req   = 1'b1;
        o_mem_we    = i_lsu_we;
        o_mem_addr  = i_lsu_addr;
        o_mem_wdata = i_lsu_wdata;
        o_mem_be    = i_lsu_be;
      end else if (own_f) begin
        o_mem_req   = 1'b1;
        o_mem_addr  = i_fetch_addr;
        o_mem_be    = 4'hF;
      end
      o_fetch_gnt    = fetch_gnt;
      o_lsu_gnt      = lsu_gnt;
      o_fetch_rvalid = fetch_rvalid;
      o_lsu_rvalid   = lsu_rvalid;
      if (fetch_rvalid) o_fetch_rdata = i_mem_rdata;
      if (lsu_rvalid)   o_lsu_rdata   = i_mem_rdata;
    end
  end

endmodule

// File: tb/tb_zacore_mem_arbiter.sv
// Scoreboard bench for zacore_mem_arbiter: directed stimulus pushes expected
// responses, a negedge monitor pops and compares them.
module tb_zacore_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_fetch_req;
  logic [31:0] i_fetch_addr;
  logic        o_fetch_gnt;
  logic        o_fetch_rvalid;
  logic [31:0] o_fetch_rdata;
  logic        i_lsu_req;
  logic        i_lsu_we;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_lsu_wdata;
  logic [3:0]  i_lsu_be;
  logic        o_lsu_gnt;
  logic        o_lsu_rvalid;
  logic [31:0] o_lsu_rdata;
  logic        i_invalidate;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] exp_fetch_q[$];
  logic [31:0] exp_lsu_q[$];

  zacore_mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_fetch_req(i_fetch_req), .i_fetch_addr(i_fetch_addr),
    .o_fetch_gnt(o_fetch_gnt), .o_fetch_rvalid(o_fetch_rvalid),
    .o_fetch_rdata(o_fetch_rdata),
    .i_lsu_req(i_lsu_req), .i_lsu_we(i_lsu_we), .i_lsu_addr(i_lsu_addr),
    .i_lsu_wdata(i_lsu_wdata), .i_lsu_be(i_lsu_be),
    .o_lsu_gnt(o_lsu_gnt), .o_lsu_rvalid(o_lsu_rvalid), .o_lsu_rdata(o_lsu_rdata),
    .i_invalidate(i_invalidate),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge i_clk);
  endtask

  // Monitor: every presented response must match the oldest expected one.
  always @(negedge i_clk) begin
    if (o_fetch_rvalid) begin
      if (exp_fetch_q.size() == 0) chk("fetch_rvalid_unexpected", 32'd1, 32'd0);
      else chk("fetch_rdata", o_fetch_rdata, exp_fetch_q.pop_front());
    end else if (i_mem_rvalid) begin
      chk("fetch_rdata_quiet", o_fetch_rdata, 32'h0);
    end
    if (o_lsu_rvalid) begin
      if (exp_lsu_q.size() == 0) chk("lsu_rvalid_unexpected", 32'd1, 32'd0);
      else chk("lsu_rdata", o_lsu_rdata, exp_lsu_q.pop_front());
    end else if (i_mem_rvalid) begin
      chk("lsu_rdata_quiet", o_lsu_rdata, 32'h0);
    end
  end

  // Fetch-only transaction starting in IDLE: issue, one wait cycle, rvalid.
  // inv_at: 0 none, 1 issue cycle, 2 wait cycle, 3 rvalid cycle.
  task automatic fetch_txn(input logic [31:0] addr, input logic [31:0] data,
                           input int unsigned inv_at);
    i_fetch_req = 1'b1; i_fetch_addr = addr; i_mem_gnt = 1'b1;
    i_invalidate = (inv_at == 1);
    at_neg();
    chk("fetch_gnt", {31'b0, o_fetch_gnt}, 32'd1);
    chk("fetch_addr", o_mem_addr, addr);
    chk("fetch_be", {28'b0, o_mem_be}, 32'hF);
    chk("fetch_we", {31'b0, o_mem_we}, 32'd0);
    if (inv_at == 0) exp_fetch_q.push_back(data);
    step();
    i_fetch_req = 1'b0; i_mem_gnt = 1'b0; i_invalidate = (inv_at == 2);
    at_neg();
    chk("wait_no_req", {31'b0, o_mem_req}, 32'd0);
    step();
    i_mem_rvalid = 1'b1; i_mem_rdata = data; i_invalidate = (inv_at == 3);
    at_neg();
    if (inv_at != 0) chk("fetch_dropped", {31'b0, o_fetch_rvalid}, 32'd0);
    chk("rvalid_no_issue", {31'b0, o_mem_req}, 32'd0);
    step();
    i_mem_rvalid = 1'b0; i_mem_rdata = '0; i_invalidate = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b0;
    i_fetch_req = 1'b1; i_fetch_addr = 32'h100;
    i_lsu_req = 1'b1; i_lsu_we = 1'b1; i_lsu_addr = 32'h8000;
    i_lsu_wdata = 32'h55; i_lsu_be = 4'b0001;
    i_invalidate = 1'b0; i_mem_gnt = 1'b1; i_mem_rvalid = 1'b0; i_mem_rdata = '0;

    // Reset: outputs low even with requests and a grant present.
    at_neg();
    chk("rst_mem_req", {31'b0, o_mem_req}, 32'd0);
    chk("rst_fetch_gnt", {31'b0, o_fetch_gnt}, 32'd0);
    chk("rst_lsu_gnt", {31'b0, o_lsu_gnt}, 32'd0);
    chk("rst_mem_addr", o_mem_addr, 32'h0);
    step();
    i_rst = 1'b1; i_fetch_req = 1'b0; i_lsu_req = 1'b0; i_mem_gnt = 1'b0;
    at_neg();
    chk("idle_mem_req", {31'b0, o_mem_req}, 32'd0);
    step();

    // Fetch only.
    fetch_txn(32'h100, 32'hDEADBEEF, 0);

    // Simultaneous fetch and LSU store: LSU first.
    i_fetch_req = 1'b1; i_fetch_addr = 32'h200;
    i_lsu_req = 1'b1; i_lsu_we = 1'b1; i_lsu_addr = 32'h8000;
    i_lsu_wdata = 32'h55; i_lsu_be = 4'b0001; i_mem_gnt = 1'b1;
    at_neg();
    chk("both_lsu_gnt", {31'b0, o_lsu_gnt}, 32'd1);
    chk("both_fetch_gnt", {31'b0, o_fetch_gnt}, 32'd0);
    chk("both_addr", o_mem_addr, 32'h8000);
    chk("both_we", {31'b0, o_mem_we}, 32'd1);
    chk("both_be", {28'b0, o_mem_be}, 32'h1);
    chk("both_wdata", o_mem_wdata, 32'h55);
    exp_lsu_q.push_back(32'h0);
    step();
    i_lsu_req = 1'b0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0;
    at_neg();
    chk("both_no_issue_rvalid", {31'b0, o_mem_req}, 32'd0);
    step();
    i_mem_rvalid = 1'b0; i_mem_gnt = 1'b1;
    at_neg();
    chk("both_fetch_second", {31'b0, o_fetch_gnt}, 32'd1);
    chk("both_fetch_addr", o_mem_addr, 32'h200);
    exp_fetch_q.push_back(32'h12345678);
    step();
    i_fetch_req = 1'b0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h12345678;
    step();
    i_mem_rvalid = 1'b0; i_mem_rdata = '0;

    // Starvation: fetch loses 4 times, wins the 5th, then LSU wins again.
    i_lsu_we = 1'b0; i_lsu_addr = 32'h9000; i_lsu_be = 4'hF; i_lsu_wdata = '0;
    i_fetch_addr = 32'h400;
    for (int k = 0; k < 6; k++) begin
      i_fetch_req = 1'b1; i_lsu_req = 1'b1; i_mem_gnt = 1'b1;
      at_neg();
      chk("starve_fetch_gnt", {31'b0, o_fetch_gnt}, (k == 4) ? 32'd1 : 32'd0);
      chk("starve_lsu_gnt", {31'b0, o_lsu_gnt}, (k == 4) ? 32'd0 : 32'd1);
      if (k == 4) exp_fetch_q.push_back(32'hF0F00004);
      else exp_lsu_q.push_back(32'hA0000000 + k);
      step();
      i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1;
      i_mem_rdata = (k == 4) ? 32'hF0F00004 : 32'hA0000000 + k;
      step();
      i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    end
    i_fetch_req = 1'b0; i_lsu_req = 1'b0;

    // Fetch locked in REQ_F while LSU arrives; granted in cycle 3.
    i_fetch_req = 1'b1; i_fetch_addr = 32'h500; i_mem_gnt = 1'b0;
    for (int c = 0; c < 4; c++) begin
      i_lsu_req = (c != 0); i_mem_gnt = (c == 3);
      at_neg();
      chk("lock_addr", o_mem_addr, 32'h500);
      chk("lock_lsu_gnt", {31'b0, o_lsu_gnt}, 32'd0);
      chk("lock_fetch_gnt", {31'b0, o_fetch_gnt}, (c == 3) ? 32'd1 : 32'd0);
      step();
    end
    exp_fetch_q.push_back(32'h0BADF00D);
    i_fetch_req = 1'b0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0BADF00D;
    step();
    i_mem_rvalid = 1'b0; i_mem_gnt = 1'b1;
    at_neg();
    chk("lock_lsu_after", {31'b0, o_lsu_gnt}, 32'd1);
    exp_lsu_q.push_back(32'hCAFE0001);
    step();
    i_lsu_req = 1'b0; i_mem_gnt = 1'b0; i_invalidate = 1'b1;
    step();
    // Invalidate in WAIT_L is ignored.
    i_invalidate = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hCAFE0001;
    step();
    i_invalidate = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;

    // Invalidate variants, each followed by a normal fetch.
    fetch_txn(32'h600, 32'h00000BAD, 2);
    fetch_txn(32'h604, 32'h11111111, 0);
    fetch_txn(32'h608, 32'h00000BAD, 3);
    fetch_txn(32'h60C, 32'h22222222, 0);
    fetch_txn(32'h610, 32'h00000BAD, 1);
    fetch_txn(32'h614, 32'h33333333, 0);

    // Reset during WAIT_L, then a stray rvalid.
    i_lsu_req = 1'b1; i_lsu_we = 1'b0; i_lsu_addr = 32'h4000; i_mem_gnt = 1'b1;
    at_neg();
    chk("rstmid_lsu_gnt", {31'b0, o_lsu_gnt}, 32'd1);
    step();
    i_lsu_req = 1'b0; i_mem_gnt = 1'b0;
    i_rst = 1'b0;
    i_fetch_req = 1'b1; i_mem_gnt = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h77;
    at_neg();
    chk("rstmid_mem_req", {31'b0, o_mem_req}, 32'd0);
    chk("rstmid_lsu_rvalid", {31'b0, o_lsu_rvalid}, 32'd0);
    chk("rstmid_fetch_gnt", {31'b0, o_fetch_gnt}, 32'd0);
    step();
    i_rst = 1'b1; i_fetch_req = 1'b0; i_mem_gnt = 1'b0;
    at_neg();
    chk("stray_lsu_rvalid", {31'b0, o_lsu_rvalid}, 32'd0);
    chk("stray_fetch_rvalid", {31'b0, o_fetch_rvalid}, 32'd0);
    chk("stray_mem_req", {31'b0, o_mem_req}, 32'd0);
    step();
    i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    fetch_txn(32'h700, 32'h44444444, 0);

    step();
    chk("fetch_q_drained", exp_fetch_q.size(), 32'd0);
    chk("lsu_q_drained", exp_lsu_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
